// File: rtl/wb_data_mem.sv
// Pipelined Wishbone-style data responder: in-order request queue, fixed
// wait states per access, sub-word write merge and lane-aligned reads.
module wb_data_mem #(
  parameter int ADDR_W     = 10,
  parameter int WAIT       = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        data_stb_in,
  input  logic        data_we_in,
  input  logic [1:0]  data_be_in,
  input  logic [31:0] data_addr_in,
  input  logic [31:0] data_data_in,
  output logic        data_stall_out,
  output logic        data_ack_out,
  output logic [31:0] data_data_out,
  output logic        err_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [2:0] RELOAD = 3'(WAIT - 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0]   q_addr [FIFO_DEPTH];
  logic [31:0]   q_data [FIFO_DEPTH];
  logic          q_we   [FIFO_DEPTH];
  logic [1:0]    q_be   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, fire;
  state_t        state, state_nx;
  logic [2:0]    cnt, cnt_nx;
  logic [31:0]   cur_addr, cur_data;
  logic          cur_we;
  logic [1:0]    cur_be;

  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [4:0]        sh;
  logic [31:0]       word, lanes, mask, merged, rdata;
  logic              bad;

  assign data_stall_out = (count == FULL);
  assign push = data_stb_in && !data_stall_out;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          cnt_nx   = RELOAD;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          fire = 1'b1;
          if (count != '0) begin
            pop    = 1'b1;
            cnt_nx = RELOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= data_addr_in;
      q_data[wr_ptr] <= data_data_in;
      q_we[wr_ptr]   <= data_we_in;
      q_be[wr_ptr]   <= data_be_in;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (pop) begin
      cur_addr <= q_addr[rd_ptr];
      cur_data <= q_data[rd_ptr];
      cur_we   <= q_we[rd_ptr];
      cur_be   <= q_be[rd_ptr];
    end
  end

  // Access decode: lane shift, alignment/range check, write merge mask
  always_comb begin
    idx   = cur_addr[ADDR_W+1:2];
    sh    = {cur_addr[1:0], 3'b000};
    word  = ram[idx];
    lanes = word >> sh;
    bad   = (cur_addr[31:ADDR_W+2] != '0);
    mask  = '1;
    rdata = lanes;
    unique case (1'b1)
      cur_be[1]: begin
        bad = bad | (cur_addr[1:0] != 2'b00);
      end
      (cur_be == 2'b01): begin
        bad   = bad | cur_addr[0];
        mask  = 32'h0000_ffff << sh;
        rdata = {16'h0, lanes[15:0]};
      end
      default: begin
        mask  = 32'h0000_00ff << sh;
        rdata = {24'h0, lanes[7:0]};
      end
    endcase
    merged = (word & ~mask) | ((cur_data << sh) & mask);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst && fire && cur_we && !bad) ram[idx] <= merged;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      data_ack_out  <= 1'b0;
      data_data_out <= '0;
      err_out       <= 1'b0;
    end else begin
      data_ack_out  <= fire;
      err_out       <= fire && bad;
      data_data_out <= (fire && !bad && !cur_we) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_wb_data_mem.sv
// Bench for wb_data_mem: two instances (WAIT=2 and WAIT=1) checked every
// cycle against a transaction-level model, plus literal spot checks.
module tb_wb_data_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stb   [2];
  logic        we    [2];
  logic [1:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        stall [2];
  logic        ack   [2];
  logic [31:0] dout  [2];
  logic        err   [2];

  wb_data_mem #(.ADDR_W(10), .WAIT(2), .FIFO_DEPTH(2)) u_dut0 (
    .sys_clk(clk), .sys_rst(rst_n),
    .data_stb_in(stb[0]), .data_we_in(we[0]),
    .data_be_in(be[0]), .data_addr_in(addr[0]),
    .data_data_in(wdata[0]), .data_stall_out(stall[0]),
    .data_ack_out(ack[0]), .data_data_out(dout[0]),
    .err_out(err[0])
  );

  wb_data_mem #(.ADDR_W(10), .WAIT(1), .FIFO_DEPTH(2)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst_n),
    .data_stb_in(stb[1]), .data_we_in(we[1]),
    .data_be_in(be[1]), .data_addr_in(addr[1]),
    .data_data_in(wdata[1]), .data_stall_out(stall[1]),
    .data_ack_out(ack[1]), .data_data_out(dout[1]),
    .err_out(err[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model state: pending requests with their due completion edge
  int          ecnt = 0;
  logic        stl_q [2] = '{1'b0, 1'b0};
  logic [31:0] r_addr [2][16];
  logic [31:0] r_wd   [2][16];
  logic        r_we   [2][16];
  logic [1:0]  r_be   [2][16];
  int          r_ex   [2][16];
  int          hd [2] = '{0, 0};
  int          tl [2] = '{0, 0};
  int          last_ex [2] = '{-100, -100};
  logic [31:0] mm [2][1024];
  int          nack [2] = '{0, 0};
  int          dut_acks [2] = '{0, 0};
  int          aedge [2][64];
  logic [31:0] adata [2][64];
  logic        aerr  [2][64];

  function automatic int wt(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic model_exec(int i, int k, output logic [31:0] d,
                            output logic e);
    logic [31:0] a;
    int n, off, w;
    a = r_addr[i][k];
    n = (r_be[i][k] == 2'b00) ? 1 : (r_be[i][k] == 2'b01) ? 2 : 4;
    e = (a >= 32'd4096) || (a % n != 0);
    d = '0;
    if (!e) begin
      w = int'(a / 4);
      off = int'(a % 4);
      for (int b = 0; b < n; b++) begin
        if (r_we[i][k])
          mm[i][w][8*(off+b) +: 8] = r_wd[i][k][8*b +: 8];
        else
          d[8*b +: 8] = mm[i][w][8*(off+b) +: 8];
      end
    end
  endtask

  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        hd[i] = 0;
        tl[i] = 0;
        last_ex[i] = -100;
      end else if (stb[i] && !stl_q[i]) begin
        int ex;
        ex = ecnt + 1 + wt(i);
        if (last_ex[i] + wt(i) > ex) ex = last_ex[i] + wt(i);
        r_addr[i][tl[i]%16] = addr[i];
        r_wd[i][tl[i]%16]   = wdata[i];
        r_we[i][tl[i]%16]   = we[i];
        r_be[i][tl[i]%16]   = be[i];
        r_ex[i][tl[i]%16]   = ex;
        tl[i]++;
        last_ex[i] = ex;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int pend;
      logic xa, ee;
      logic [31:0] ed;
      stl_q[i] = stall[i];
      if (ack[i] === 1'b1) dut_acks[i]++;
      pend = 0;
      for (int j = hd[i]; j < tl[i]; j++)
        if (r_ex[i][j%16] - wt(i) > ecnt) pend++;
      chk($sformatf("stall%0d@%0d", i, ecnt), stall[i], pend == 2);
      xa = (hd[i] != tl[i]) && (r_ex[i][hd[i]%16] == ecnt);
      chk($sformatf("ack%0d@%0d", i, ecnt), ack[i], xa);
      if (xa) begin
        model_exec(i, hd[i] % 16, ed, ee);
        hd[i]++;
        chk($sformatf("data%0d@%0d", i, ecnt), dout[i], ed);
        chk($sformatf("err%0d@%0d", i, ecnt), err[i], ee);
        aedge[i][nack[i]] = ecnt;
        adata[i][nack[i]] = dout[i];
        aerr[i][nack[i]]  = err[i];
        nack[i]++;
      end
    end
  end

  task automatic req(int i, bit w, bit [1:0] b, bit [31:0] a,
                     bit [31:0] d, output int acc);
    int n;
    stb[i] = 1'b1;
    we[i] = w;
    be[i] = b;
    addr[i] = a;
    wdata[i] = d;
    n = 0;
    forever begin
      @(posedge clk);
      if (!stl_q[i]) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout%0d addr=%h", i, a);
        break;
      end
    end
    @(negedge clk);
    acc = ecnt;
  endtask

  task automatic idle(int i, int n);
    stb[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int acc, dmy, n0, a0;
    for (int i = 0; i < 2; i++) begin
      stb[i] = 1'b0;
      we[i] = 1'b0;
      be[i] = 2'b00;
      addr[i] = '0;
      wdata[i] = '0;
      for (int k = 0; k < 1024; k++) mm[i][k] = '0;
    end

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack[0], 0);
    chk("rst_stall", stall[0], 0);
    chk("rst_data", dout[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_ack1", ack[1], 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_acks", dut_acks[0] + dut_acks[1], 0);

    n0 = nack[0];
    req(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, acc);
    req(0, 0, 2'b10, 32'h10, 0, dmy);
    idle(0, 12);
    chk("latency", aedge[0][n0] - acc, 3);
    chk("rd_word", adata[0][n0+1], 32'hDEADBEEF);
    chk("rd_word_err", aerr[0][n0+1], 0);

    n0 = nack[0];
    req(0, 1, 2'b10, 32'h10, 32'h11223344, dmy);
    req(0, 1, 2'b00, 32'h11, 32'h000000AA, dmy);
    req(0, 0, 2'b00, 32'h11, 0, dmy);
    req(0, 0, 2'b01, 32'h12, 0, dmy);
    req(0, 0, 2'b10, 32'h10, 0, dmy);
    idle(0, 14);
    chk("rd_byte", adata[0][n0+2], 32'h000000AA);
    chk("rd_half", adata[0][n0+3], 32'h00001122);
    chk("rd_merged", adata[0][n0+4], 32'h1122AA44);

    n0 = nack[1];
    a0 = dut_acks[1];
    for (int k = 0; k < 4; k++)
      req(1, 1, 2'b10, 32'h20 + 4*k, 32'hA0000000 + k, dmy);
    for (int k = 0; k < 4; k++)
      req(1, 0, 2'b10, 32'h20 + 4*k, 0, dmy);
    idle(1, 10);
    chk("b2b_acks", dut_acks[1] - a0, 8);
    chk("b2b_spacing", aedge[1][n0+7] - aedge[1][n0+4], 3);
    for (int k = 0; k < 4; k++)
      chk($sformatf("b2b_rd%0d", k), adata[1][n0+4+k], 32'hA0000000 + k);

    n0 = nack[0];
    req(0, 1, 2'b10, 32'h4, 32'h55667788, dmy);
    req(0, 0, 2'b01, 32'h3, 0, dmy);
    req(0, 1, 2'b10, 32'h6, 32'hFFFFFFFF, dmy);
    req(0, 0, 2'b10, 32'h00100000, 0, dmy);
    req(0, 0, 2'b10, 32'h4, 0, dmy);
    req(0, 0, 2'b00, 32'h7, 0, dmy);
    req(0, 1, 2'b11, 32'hFFC, 32'h01020304, dmy);
    req(0, 0, 2'b01, 32'hFFE, 0, dmy);
    req(0, 0, 2'b10, 32'h1000, 0, dmy);
    idle(0, 24);
    chk("err_half", aerr[0][n0+1], 1);
    chk("err_half_d", adata[0][n0+1], 0);
    chk("err_word_wr", aerr[0][n0+2], 1);
    chk("err_oob", aerr[0][n0+3], 1);
    chk("err_oob_d", adata[0][n0+3], 0);
    chk("unchanged", adata[0][n0+4], 32'h55667788);
    chk("rd_byte7", adata[0][n0+5], 32'h00000055);
    chk("rd_top_half", adata[0][n0+7], 32'h00000102);
    chk("err_edge", aerr[0][n0+8], 1);

    req(0, 1, 2'b10, 32'h30, 32'h12345678, dmy);
    idle(0, 8);
    req(0, 1, 2'b10, 32'h30, 32'hCAFEF00D, dmy);
    req(0, 1, 2'b10, 32'h34, 32'h1, dmy);
    req(0, 1, 2'b10, 32'h38, 32'h2, dmy);
    chk("pre_rst_stall", stall[0], 1);
    stb[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = dut_acks[0];
    idle(0, 10);
    chk("rst_no_acks", dut_acks[0] - a0, 0);
    n0 = nack[0];
    req(0, 0, 2'b10, 32'h30, 0, acc);
    idle(0, 8);
    chk("post_rst_lat", aedge[0][n0] - acc, 3);
    chk("post_rst_rd", adata[0][n0], 32'h12345678);

    chk("drain0", tl[0] - hd[0], 0);
    chk("drain1", tl[1] - hd[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
